capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_ctrl.sv | 125 ++++++++++++
 tb/tb_capture_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: paced ADC capture into a DEPTH-entry buffer with an
// optional rising-level trigger and a Pi read-back handshake.
module capture_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DIV   = 50
) (
  input  logic          osc_clk,
  input  logic          reset,
  input  logic          trig_en,
  input  logic [7:0]    trig_level,
  input  logic          pi_done,
  input  logic          adc_valid,
  input  logic [7:0]    adc_sample,
  output logic          adc_start,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [7:0]    mem_wdata,
  output logic          pi_signal_flag,
  output logic          overrun,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } st_t;

  localparam logic [15:0]   TOP  = 16'(DIV - 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  st_t           st;
  logic [15:0]   timer;
  logic          tick;
  logic          busy;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    prev;
  logic [2:0]    pd_q;
  logic          pd_edge;
  logic          accept;
  logic          trig_hit;

  assign state    = st;
  assign pd_edge  = pd_q[1] & ~pd_q[2];
  assign accept   = adc_valid & busy & (st != READY);
  assign trig_hit = ~trig_en |
                    ((prev < trig_level) & (adc_sample >= trig_level));

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      st             <= ARM;
      timer          <= '0;
      tick           <= 1'b0;
      busy           <= 1'b0;
      wr_ptr         <= '0;
      prev           <= 8'hFF;
      pd_q           <= '0;
      adc_start      <= 1'b0;
      mem_we         <= 1'b0;
      mem_adr        <= '0;
      mem_wdata      <= '0;
      pi_signal_flag <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      pd_q      <= {pd_q[1:0], pi_done};
      adc_start <= 1'b0;
      mem_we    <= 1'b0;
      unique case (st)
        ARM, FILL: begin
          if (timer == TOP) begin
            timer <= '0;
            tick  <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
            tick  <= 1'b0;
          end
          // a tick that finds a conversion in flight is dropped
          if (tick && !busy) begin
            adc_start <= 1'b1;
            busy      <= 1'b1;
          end else if (tick) begin
            overrun <= 1'b1;
          end
          if (accept) begin
            busy <= 1'b0;
            prev <= adc_sample;
            if (st == FILL) begin
              mem_we    <= 1'b1;
              mem_adr   <= wr_ptr;
              mem_wdata <= adc_sample;
              wr_ptr    <= wr_ptr + AW'(1);
              if (wr_ptr == LAST) begin
                st             <= READY;
                pi_signal_flag <= 1'b1;
                timer          <= '0;
                tick           <= 1'b0;
              end
            end else if (trig_hit) begin
              mem_we    <= 1'b1;
              mem_adr   <= '0;
              mem_wdata <= adc_sample;
              wr_ptr    <= AW'(1);
              st        <= FILL;
            end
          end
        end
        READY: begin
          timer <= '0;
          tick  <= 1'b0;
          if (pd_edge) begin
            st             <= ARM;
            pi_signal_flag <= 1'b0;
            overrun        <= 1'b0;
            busy           <= 1'b0;
            wr_ptr         <= '0;
            prev           <= 8'hFF;
          end
        end
        default: st <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: trigger vector table, handshake/overrun/reset
// sequences and random captures against a trigger-and-fill model.
module tb_capture_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DIV   = 4;

  logic          osc_clk = 1'b0;
  logic          reset = 1'b1;
  logic          trig_en = 1'b0;
  logic [7:0]    trig_level = 8'h80;
  logic          pi_done = 1'b0;
  logic          adc_valid = 1'b0;
  logic [7:0]    adc_sample = 8'h00;
  logic          adc_start;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [7:0]    mem_wdata;
  logic          pi_signal_flag;
  logic          overrun;
  logic [1:0]    state;

  capture_ctrl #(.DEPTH(DEPTH), .AW(AW), .DIV(DIV)) dut (
    .osc_clk        (osc_clk),
    .reset          (reset),
    .trig_en        (trig_en),
    .trig_level     (trig_level),
    .pi_done        (pi_done),
    .adc_valid      (adc_valid),
    .adc_sample     (adc_sample),
    .adc_start      (adc_start),
    .mem_we         (mem_we),
    .mem_adr        (mem_adr),
    .mem_wdata      (mem_wdata),
    .pi_signal_flag (pi_signal_flag),
    .overrun        (overrun),
    .state          (state)
  );

  always #5 osc_clk = ~osc_clk;

  typedef struct packed {
    logic        en;
    logic [7:0]  lvl;
    logic [31:0] lead;
    logic [7:0]  first;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pend  = 0;
  int lat   = 2;
  int src_i = 0;
  logic [7:0]    src [64];
  logic [AW-1:0] w_adr [$];
  logic [7:0]    w_dat [$];
  int            st_cyc [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // one clock: log DUT activity, then play the ADC for the next cycle
  task automatic step();
    @(posedge osc_clk);
    #1;
    cyc++;
    if (mem_we) begin
      w_adr.push_back(mem_adr);
      w_dat.push_back(mem_wdata);
    end
    if (adc_start) st_cyc.push_back(cyc);
    adc_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        adc_valid  = 1'b1;
        adc_sample = (src_i < 64) ? src[src_i] : 8'h00;
        src_i++;
      end
    end
    if (adc_start) pend = lat;
  endtask

  function automatic logic hit(input int what);
    case (what)
      0:       return pi_signal_flag;
      1:       return state == 2'd1;
      2:       return w_adr.size() >= 8;
      default: return adc_start;
    endcase
  endfunction

  task automatic wait_for(input int what, input int bound,
                          input string nm, output int n);
    n = 0;
    while (!hit(what) && n < bound) begin
      step();
      n++;
    end
    chk({nm, "_timeout"}, n < bound, 1);
  endtask

  task automatic clear_log();
    w_adr.delete();
    w_dat.delete();
    st_cyc.delete();
    src_i = 0;
    pend  = 0;
  endtask

  task automatic rearm();
    clear_log();
    pi_done = 1'b1;
    repeat (4) step();
    pi_done = 1'b0;
    step();
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) src[i] = 8'(i);
  endtask

  // first accepted sample that satisfies the trigger rule
  function automatic int find_trig(input logic en, input logic [7:0] lvl);
    logic [7:0] p;
    p = 8'hFF;
    for (int i = 0; i < 64; i++) begin
      if (!en || (p < lvl && src[i] >= lvl)) return i;
      p = src[i];
    end
    return 0;
  endfunction

  task automatic check_writes(input string nm, input int t);
    chk({nm, "_count"}, w_adr.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < w_adr.size(); i++)
      chk($sformatf("%s_w%0d", nm, i), {w_adr[i], w_dat[i]},
          {AW'(i), src[(t + i) & 63]});
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_state"}, state, 0);
    chk({nm, "_start"}, adc_start, 0);
    chk({nm, "_we"}, mem_we, 0);
    chk({nm, "_adr"}, mem_adr, 0);
    chk({nm, "_wdata"}, mem_wdata, 0);
    chk({nm, "_flag"}, pi_signal_flag, 0);
    chk({nm, "_ovr"}, overrun, 0);
  endtask

  initial begin
    vec_t tbl [5];
    int   n, m, k, t, lv;
    logic en;

    tbl[0] = '{1'b1, 8'h80, {8'd10, 8'd50, 8'd120, 8'd130}, 8'd130};
    tbl[1] = '{1'b0, 8'h80, {8'd10, 8'd50, 8'd120, 8'd130}, 8'd10};
    tbl[2] = '{1'b1, 8'd16, {8'd5, 8'd16, 8'd200, 8'd3}, 8'd16};
    tbl[3] = '{1'b1, 8'd40, {8'd200, 8'd100, 8'd30, 8'd40}, 8'd40};
    tbl[4] = '{1'b1, 8'd1, {8'hFF, 8'd0, 8'd1, 8'd2}, 8'd1};

    // free run from reset
    fill_ramp();
    lat = 2;
    repeat (3) @(posedge osc_clk);
    #1;
    chk_rst("rst");
    reset = 1'b0;
    wait_for(3, 50, "first_start", n);
    chk("start_lat", n, DIV + 1);
    wait_for(0, 400, "free_full", n);
    check_writes("free", 0);
    chk("free_ovr", overrun, 0);
    k = st_cyc.size();
    repeat (20) step();
    chk("ready_nostart", st_cyc.size(), k);
    chk("ready_state", state, 2);

    // stray adc_valid while READY
    k = w_adr.size();
    adc_valid  = 1'b1;
    adc_sample = 8'h55;
    repeat (4) step();
    chk("spur_rdy_we", w_adr.size(), k);
    chk("spur_rdy_state", state, 2);

    // long pi_done pulse re-arms; a later pulse in FILL is ignored
    trig_en    = 1'b1;
    trig_level = 8'h80;
    for (int i = 0; i < 64; i++)
      src[i] = (i < 30) ? 8'h00 : 8'(8'h90 + i - 30);
    clear_log();
    pi_done = 1'b1;
    m = 0;
    while (state != 2'd0 && m < 8) begin
      step();
      m++;
    end
    chk("pi_edge_lat", m <= 3, 1);
    chk("pi_flag_clr", pi_signal_flag, 0);
    wait_for(3, 50, "rearm_start", n);
    chk("rearm_lat", n, DIV + 1);
    repeat (100 - m - n) step();
    pi_done = 1'b0;
    chk("hold_arm", state, 0);
    wait_for(1, 400, "to_fill", n);
    pi_done = 1'b1;
    repeat (3) step();
    pi_done = 1'b0;
    repeat (5) step();
    chk("fill_ignore_pi", state, 1);
    chk("fill_flag", pi_signal_flag, 0);
    wait_for(0, 400, "hs_full", n);
    check_writes("hs", find_trig(1'b1, 8'h80));

    // trigger vector table
    for (int v = 0; v < 5; v++) begin
      trig_en    = tbl[v].en;
      trig_level = tbl[v].lvl;
      for (int j = 0; j < 4; j++) src[j] = tbl[v].lead[31 - 8*j -: 8];
      for (int i = 4; i < 64; i++) src[i] = 8'(src[3] + i - 3);
      rearm();
      wait_for(0, 400, $sformatf("vec%0d_full", v), n);
      chk($sformatf("vec%0d_count", v), w_dat.size(), DEPTH);
      chk($sformatf("vec%0d_first", v),
          (w_dat.size() > 0) ? {w_adr[0], w_dat[0]} : 12'hFFF,
          {AW'(0), tbl[v].first});
    end

    // random captures against the model
    for (int r = 0; r < 6; r++) begin
      lv  = $urandom_range(1, 255);
      en  = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 2);
      for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
      k = $urandom_range(1, 40);
      src[k-1] = 8'($urandom_range(0, lv - 1));
      src[k]   = 8'($urandom_range(lv, 255));
      trig_en    = en;
      trig_level = 8'(lv);
      rearm();
      wait_for(0, 400, $sformatf("rnd%0d_full", r), n);
      t = find_trig(en, 8'(lv));
      check_writes($sformatf("rnd%0d", r), t);
      chk($sformatf("rnd%0d_ovr", r), overrun, 0);
    end

    // slow ADC: every other tick dropped, overrun sticky until re-arm
    trig_en = 1'b0;
    fill_ramp();
    lat = 6;
    rearm();
    wait_for(0, 600, "ovr_full", n);
    chk("ovr_set", overrun, 1);
    check_writes("ovr", 0);
    chk("ovr_skip", (st_cyc.size() >= 3) ? st_cyc[2] - st_cyc[1] : 0,
        2 * DIV);
    lat = 2;
    rearm();
    chk("ovr_clr", overrun, 0);

    // asynchronous reset in the middle of FILL
    wait_for(2, 300, "to_adr7", n);
    chk("adr7", mem_adr, 7);
    #3 reset = 1'b1;
    #1;
    chk_rst("midrst");
    pend      = 0;
    adc_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    clear_log();
    chk("postrst_flag", pi_signal_flag, 0);
    adc_valid  = 1'b1;
    adc_sample = 8'h77;
    repeat (3) step();
    chk("spur_arm_we", w_adr.size(), 0);
    chk("spur_arm_state", state, 0);
    wait_for(0, 400, "postrst_full", n);
    check_writes("postrst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
